mdu_iter_engine: RTL



---
 rtl/mdu_pkg.sv | 42 ++++
 rtl/mdu_abs_neg.sv | 24 ++
 rtl/mdu_iter_engine.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared types and helpers for the iterative multiply/divide
//                engine: opcode encoding, FSM state encoding, default width
//                and opcode-decode predicates.
//  Revision    : 1.0  initial release
// ============================================================================
package mdu_pkg;

    localparam int DEFAULT_PARALLELISM = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // Divide and remainder share the upper opcode bit.
    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // Multiply variants that return the upper product half.
    function automatic logic sel_high(input logic [2:0] op);
        return op inside {3'b001, 3'b010, 3'b011};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_abs_neg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_abs_neg
//  Description : Combinational conditional two's-complement negator.
//                o_val = i_neg ? -i_val : i_val  (modulo 2^WIDTH)
//  Ports       : i_val [WIDTH-1:0] value in
//                i_neg             negate when high
//                o_val [WIDTH-1:0] value out
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    always_comb begin
        o_val = i_neg ? (~i_val + {{(WIDTH-1){1'b0}}, 1'b1}) : i_val;
    end

endmodule
`default_nettype wire

// File: rtl/mdu_iter_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_iter_engine
//  Description : Radix-2 iterative multiply / restoring divide on operand
//                magnitudes with final sign correction. One operation in
//                flight, valid/ready handshake on both sides.
//  Ports       : clk, rst_n            clock, async active-low reset
//                in_valid / in_ready   operation handshake (ready in IDLE)
//                opCode [2:0]          MUL..REMU
//                lOpExt / rOpExt       sign/zero-extended operands (P+1 bits)
//                out_valid / out_ready result handshake
//                result [P-1:0]        product half, quotient or remainder
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_iter_engine
    import mdu_pkg::*;
#(
    parameter int PARALLELISM = DEFAULT_PARALLELISM
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             opCode,
    input  logic [PARALLELISM:0]   lOpExt,
    input  logic [PARALLELISM:0]   rOpExt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PARALLELISM-1:0] result
);

    localparam int P  = PARALLELISM;
    localparam int CW = $clog2(P);
    localparam logic [CW-1:0] C_LAST = CW'(P - 1);

    mdu_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    op_q, op_d;
    logic          sl_q, sl_d, sr_q, sr_d;
    logic          dbz_q, dbz_d;
    logic [P-1:0]  opa_q, opa_d;     // multiplicand (mul) or divisor (div) magnitude
    logic [P-1:0]  hi_q, hi_d;       // product high half / remainder
    logic [P-1:0]  lo_q, lo_d;       // multiplier-then-product low half / quotient
    logic [P-1:0]  result_q, result_d;

    // Operand magnitudes. Negating only the low P bits is exact because every
    // legal extended value has a magnitude below 2^P.
    logic [P-1:0] w_l_mag, w_r_mag;

    mdu_abs_neg #(.WIDTH(P)) u_abs_l (
        .i_val (lOpExt[P-1:0]),
        .i_neg (lOpExt[P]),
        .o_val (w_l_mag)
    );

    mdu_abs_neg #(.WIDTH(P)) u_abs_r (
        .i_val (rOpExt[P-1:0]),
        .i_neg (rOpExt[P]),
        .o_val (w_r_mag)
    );

    // Multiply step: conditional add into the high half with carry-out, the
    // carry then becomes the new MSB after the right shift.
    logic [P:0] w_mul_sum;
    assign w_mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : {(P+1){1'b0}});

    // Restoring divide step. The shifted partial remainder needs one extra
    // bit; after a successful subtract it always fits back into P bits.
    logic [P:0]   w_div_sh;
    logic         w_div_ge;
    logic [P-1:0] w_div_rem;
    assign w_div_sh  = {hi_q, lo_q[P-1]};
    assign w_div_ge  = (w_div_sh >= {1'b0, opa_q});
    assign w_div_rem = w_div_sh[P-1:0] - opa_q;

    // Final sign correction.
    logic [2*P-1:0] w_prod;
    logic [P-1:0]   w_div_res;

    mdu_abs_neg #(.WIDTH(2*P)) u_neg_prod (
        .i_val ({hi_q, lo_q}),
        .i_neg (sl_q ^ sr_q),
        .o_val (w_prod)
    );

    // Remainder takes the dividend sign, quotient takes the sign product.
    mdu_abs_neg #(.WIDTH(P)) u_neg_div (
        .i_val (op_q[1] ? hi_q : lo_q),
        .i_neg (op_q[1] ? sl_q : (sl_q ^ sr_q)),
        .o_val (w_div_res)
    );

    logic [P-1:0] w_fix_res;
    always_comb begin
        if (!is_div(op_q)) begin
            w_fix_res = sel_high(op_q) ? w_prod[2*P-1:P] : w_prod[P-1:0];
        end else if (dbz_q) begin
            // lo_q still holds the raw dividend on this path.
            w_fix_res = op_q[1] ? lo_q : {P{1'b1}};
        end else begin
            w_fix_res = w_div_res;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        sl_d     = sl_q;
        sr_d     = sr_q;
        dbz_d    = dbz_q;
        opa_d    = opa_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = opCode;
                    sl_d    = lOpExt[P];
                    sr_d    = rOpExt[P];
                    hi_d    = '0;
                    count_d = '0;
                    dbz_d   = 1'b0;
                    if (is_div(opCode)) begin
                        opa_d = w_r_mag;
                        if (rOpExt == '0) begin
                            dbz_d   = 1'b1;
                            lo_d    = lOpExt[P-1:0];
                            state_d = ST_FIX;
                        end else begin
                            lo_d    = w_l_mag;
                            state_d = ST_CALC;
                        end
                    end else begin
                        opa_d   = w_l_mag;
                        lo_d    = w_r_mag;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (is_div(op_q)) begin
                    hi_d = w_div_ge ? w_div_rem : w_div_sh[P-1:0];
                    lo_d = {lo_q[P-2:0], w_div_ge};
                end else begin
                    hi_d = w_mul_sum[P:1];
                    lo_d = {w_mul_sum[0], lo_q[P-1:1]};
                end
                if (count_q == C_LAST) begin
                    state_d = ST_FIX;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_FIX: begin
                result_d = w_fix_res;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            op_q     <= '0;
            sl_q     <= 1'b0;
            sr_q     <= 1'b0;
            dbz_q    <= 1'b0;
            opa_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            sl_q     <= sl_d;
            sr_q     <= sr_d;
            dbz_q    <= dbz_d;
            opa_q    <= opa_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;

endmodule
`default_nettype wire
